// File: rtl/tff_count_sequencer_if.sv
// rtl/tff_count_sequencer_if.sv - control/status bundle for the T flip-flop count sequencer
//
// Purpose : groups the run request, the run controls and the bank/status
//           outputs of tff_count_sequencer into one port.
// Signals : clear, start, up, limit, steps, hold  (requester -> sequencer)
//           t_vec, q, qb, busy, done, wrap        (sequencer -> requester)
// Modports: master = requester side, slave = sequencer side.
interface tff_count_sequencer_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
);
    logic              clear;
    logic              start;
    logic              up;
    logic [WIDTH-1:0]  limit;
    logic [STEP_W-1:0] steps;
    logic              hold;
    logic [WIDTH-1:0]  t_vec;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  qb;
    logic              busy;
    logic              done;
    logic              wrap;

    modport master (
        output clear, start, up, limit, steps, hold,
        input  t_vec, q, qb, busy, done, wrap
    );

    modport slave (
        input  clear, start, up, limit, steps, hold,
        output t_vec, q, qb, busy, done, wrap
    );
endinterface

// File: rtl/tff_count_sequencer.sv
// rtl/tff_count_sequencer.sv - sequences a T flip-flop bank as an up/down modulo counter
//
// Purpose : on start, latches direction, limit and step count, then steps
//           the internal bank of WIDTH T flip-flops once per cycle (unless
//           held) through 0..limit, wrapping at either end, and pulses done
//           one cycle after the final update.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous active-low reset
//           bus   - tff_count_sequencer_if.slave (requests in, bank/status out)
module tff_count_sequencer #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    tff_count_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]  Q_ZERO   = '0;
    localparam logic [WIDTH-1:0]  Q_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0] REM_ZERO = '0;
    localparam logic [STEP_W-1:0] REM_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              up_q, up_d;
    logic [WIDTH-1:0]  limit_q, limit_d;
    logic [STEP_W-1:0] rem_q, rem_d;

    logic [WIDTH-1:0]  nxt;
    logic              wrap_step;
    logic [WIDTH-1:0]  t_vec;
    logic              wrap;

    // Next count value. The >= compare lets a bank that starts above the
    // limit fall back to 0 on its first up step.
    always_comb begin
        nxt       = Q_ZERO;
        wrap_step = 1'b0;
        if (up_q) begin
            if (q_q >= limit_q) begin
                nxt       = Q_ZERO;
                wrap_step = 1'b1;
            end else begin
                nxt = q_q + Q_ONE;
            end
        end else begin
            if (q_q == Q_ZERO) begin
                nxt       = limit_q;
                wrap_step = 1'b1;
            end else begin
                nxt = q_q - Q_ONE;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        up_d    = up_q;
        limit_d = limit_q;
        rem_d   = rem_q;
        t_vec   = Q_ZERO;
        wrap    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    up_d    = bus.up;
                    limit_d = bus.limit;
                    rem_d   = bus.steps;
                    state_d = (bus.steps != REM_ZERO) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (!bus.hold) begin
                    // Toggle exactly the bits that differ; the bank then
                    // applies q ^ t_vec like a row of T flip-flops.
                    t_vec = q_q ^ nxt;
                    wrap  = wrap_step;
                    q_d   = q_q ^ t_vec;
                    rem_d = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over start, hold and stepping; latched direction and
        // limit are left as they were so a coincident start is not taken.
        if (bus.clear) begin
            state_d = ST_IDLE;
            q_d     = Q_ZERO;
            rem_d   = REM_ZERO;
            up_d    = up_q;
            limit_d = limit_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            q_q     <= Q_ZERO;
            up_q    <= 1'b0;
            limit_q <= Q_ZERO;
            rem_q   <= REM_ZERO;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            up_q    <= up_d;
            limit_q <= limit_d;
            rem_q   <= rem_d;
        end
    end

    // While reset is low the registers are already cleared asynchronously,
    // so every output below falls to its reset value without a clock.
    assign bus.t_vec = t_vec;
    assign bus.wrap  = wrap;
    assign bus.q     = q_q;
    assign bus.qb    = ~q_q;
    assign bus.busy  = (state_q == ST_RUN);
    assign bus.done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_tff_count_sequencer.sv
// tb/tb_tff_count_sequencer.sv - directed self-checking bench for tff_count_sequencer
module tb_tff_count_sequencer;

    localparam int WIDTH  = 4;
    localparam int STEP_W = 8;

    logic clk;
    logic reset;

    tff_count_sequencer_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

    tff_count_sequencer #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       up;
        logic [3:0] limit;
        logic [7:0] steps;
        logic       hold;
        logic       clear;
        logic [3:0] e_q;
        logic [3:0] e_t;
        logic       e_busy;
        logic       e_done;
        logic       e_wrap;
    } vec_t;

    vec_t vecs[$];
    int   n_chk;
    int   n_pass;

    task automatic add(input logic st, input logic u, input logic [3:0] lim,
                       input logic [7:0] stp, input logic h, input logic clr,
                       input logic [3:0] eq, input logic [3:0] et,
                       input logic eb, input logic ed, input logic ew);
        vec_t v;
        v.start = st; v.up = u; v.limit = lim; v.steps = stp; v.hold = h; v.clear = clr;
        v.e_q = eq; v.e_t = et; v.e_busy = eb; v.e_done = ed; v.e_wrap = ew;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eq, input logic [3:0] et,
                           input logic eb, input logic ed, input logic ew);
        logic [3:0] eqb;
        eqb = ~eq;
        chk({tag, " q"},     int'(bus.q),     int'(eq));
        chk({tag, " qb"},    int'(bus.qb),    int'(eqb));
        chk({tag, " t_vec"}, int'(bus.t_vec), int'(et));
        chk({tag, " busy"},  int'(bus.busy),  int'(eb));
        chk({tag, " done"},  int'(bus.done),  int'(ed));
        chk({tag, " wrap"},  int'(bus.wrap),  int'(ew));
    endtask

    task automatic drive(input logic st, input logic u, input logic [3:0] lim,
                         input logic [7:0] stp, input logic h, input logic clr);
        bus.start = st; bus.up = u; bus.limit = lim; bus.steps = stp;
        bus.hold = h; bus.clear = clr;
    endtask

    initial begin
        int lat;
        bit seen;
        n_chk  = 0;
        n_pass = 0;

        //    st u lim  steps h clr   q     t     b d w
        // up count, limit 5, 8 steps from 0
        add(1, 1, 4'd5, 8'd8, 0, 0,  4'd0, 4'h0, 0, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd0, 4'h1, 1, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd1, 4'h3, 1, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd2, 4'h1, 1, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd3, 4'h7, 1, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd4, 4'h1, 1, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd5, 4'h5, 1, 0, 1);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd0, 4'h1, 1, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd1, 4'h3, 1, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd2, 4'h0, 0, 1, 0);
        // clear in IDLE, then one up step to reach q=1
        add(0, 0, 4'd0, 8'd0, 0, 1,  4'd2, 4'h0, 0, 0, 0);
        add(1, 1, 4'd15, 8'd1, 0, 0, 4'd0, 4'h0, 0, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd0, 4'h1, 1, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd1, 4'h0, 0, 1, 0);
        // down count, limit 9, 3 steps from 1
        add(1, 0, 4'd9, 8'd3, 0, 0,  4'd1, 4'h0, 0, 0, 0);
        add(0, 1, 4'd2, 8'd7, 0, 0,  4'd1, 4'h1, 1, 0, 0);
        add(0, 1, 4'd2, 8'd7, 0, 0,  4'd0, 4'h9, 1, 0, 1);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd9, 4'h1, 1, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd8, 4'h0, 0, 1, 0);
        // hold for 2 cycles mid-run of 4 steps, restart pulsed during RUN and DONE
        add(1, 1, 4'd15, 8'd4, 0, 0, 4'd8, 4'h0, 0, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd8, 4'h1, 1, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd9, 4'h3, 1, 0, 0);
        add(1, 0, 4'd3, 8'd0, 1, 0,  4'd10, 4'h0, 1, 0, 0);
        add(0, 0, 4'd0, 8'd0, 1, 0,  4'd10, 4'h0, 1, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd10, 4'h1, 1, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd11, 4'h7, 1, 0, 0);
        add(1, 0, 4'd3, 8'd2, 0, 0,  4'd12, 4'h0, 0, 1, 0);
        // out-of-range start: q=12, limit 5, up
        add(1, 1, 4'd5, 8'd1, 0, 0,  4'd12, 4'h0, 0, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd12, 4'hC, 1, 0, 1);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd0, 4'h0, 0, 1, 0);
        // zero steps
        add(1, 1, 4'd3, 8'd0, 0, 0,  4'd0, 4'h0, 0, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd0, 4'h0, 0, 1, 0);
        // limit 0: every step wraps back to 0
        add(1, 1, 4'd0, 8'd3, 0, 0,  4'd0, 4'h0, 0, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd0, 4'h0, 1, 0, 1);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd0, 4'h0, 1, 0, 1);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd0, 4'h0, 1, 0, 1);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd0, 4'h0, 0, 1, 0);
        // clear in 2nd RUN cycle of 6 steps, then clear coincident with start
        add(1, 1, 4'd15, 8'd6, 0, 0, 4'd0, 4'h0, 0, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd0, 4'h1, 1, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 1,  4'd1, 4'h3, 1, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd0, 4'h0, 0, 0, 0);
        add(1, 1, 4'd15, 8'd5, 0, 1, 4'd0, 4'h0, 0, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd0, 4'h0, 0, 0, 0);
        add(0, 0, 4'd0, 8'd0, 0, 0,  4'd0, 4'h0, 0, 0, 0);

        // power-on reset
        reset = 1'b0;
        drive(0, 0, 4'd0, 8'd0, 0, 0);
        @(negedge clk);
        #1;
        chk_all("reset", 4'd0, 4'h0, 0, 0, 0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].start, vecs[i].up, vecs[i].limit, vecs[i].steps,
                  vecs[i].hold, vecs[i].clear);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_q, vecs[i].e_t,
                    vecs[i].e_busy, vecs[i].e_done, vecs[i].e_wrap);
        end

        // asynchronous reset mid-run, no clock edge involved
        @(negedge clk);
        drive(1, 1, 4'd15, 8'd10, 0, 0);
        @(negedge clk);
        drive(0, 0, 4'd0, 8'd0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_all("midrun", 4'd2, 4'h1, 1, 0, 0);
        #1;
        reset = 1'b0;
        #1;
        chk_all("async_rst", 4'd0, 4'h0, 0, 0, 0);
        reset = 1'b1;
        drive(1, 1, 4'd15, 8'd2, 0, 0);
        @(negedge clk);
        drive(0, 0, 4'd0, 8'd0, 0, 0);
        #1;
        chk_all("post_rst_start", 4'd0, 4'h1, 1, 0, 0);

        // bounded wait for the completion pulse of the 2-step run
        lat  = 0;
        seen = 1'b0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (bus.done) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        chk("done_seen", int'(seen), 1);
        chk("done_latency", lat, 2);
        chk("done_q", int'(bus.q), 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
